// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared palette indices, scheduler states and sizing helper
//
// Purpose : common definitions for the frame render path.
//   - 16 four-bit palette indices (BLACK..LBLUE)
//   - sched_state_t : framebuffer write scheduler phases
//   - addr_width()  : address width able to hold w*h plus one spare bit,
//                     so that out-of-range engine addresses remain visible
// Ports   : none (package)

package render_pkg;

   localparam logic [3:0] BLACK   = 4'h0;
   localparam logic [3:0] WHITE   = 4'h1;
   localparam logic [3:0] RED     = 4'h2;
   localparam logic [3:0] CYAN    = 4'h3;
   localparam logic [3:0] PURPLE  = 4'h4;
   localparam logic [3:0] GREEN   = 4'h5;
   localparam logic [3:0] BLUE    = 4'h6;
   localparam logic [3:0] YELLOW  = 4'h7;
   localparam logic [3:0] ORANGE  = 4'h8;
   localparam logic [3:0] BROWN   = 4'h9;
   localparam logic [3:0] LRED    = 4'hA;
   localparam logic [3:0] DGRAY   = 4'hB;
   localparam logic [3:0] GRAY    = 4'hC;
   localparam logic [3:0] LGRAY   = 4'hD;
   localparam logic [3:0] LGREEN  = 4'hE;
   localparam logic [3:0] LBLUE   = 4'hF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      DRAW   = 3'd2,
      FLUSH  = 3'd3,
      FINISH = 3'd4
   } sched_state_t;

   function automatic int addr_width(input int w, input int h);
      return $clog2(w * h) + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with external pointer
//
// Purpose : grant the first requester at or after ptr, wrapping modulo N.
// Ports   :
//   req  [N]  requesters eligible this cycle
//   ptr  [PW] highest-priority index (always < N)
//   gnt  [N]  one-hot grant, zero when no request

module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   // Walk the N candidates in priority order; the extra sum bit keeps the
   // modulo wrap correct for non power-of-two N.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/framebuffer_write_scheduler.sv
// rtl/framebuffer_write_scheduler.sv - frame clear sweep plus round-robin engine write arbitration
//
// Purpose : drives framebuffer write port B for one frame. Optionally sweeps
//           every pixel with the background colour, then releases NUM_REQ
//           drawing engines and arbitrates their pixel writes round-robin.
//           Frame completes once every engine has reported done.
// Ports   :
//   clk_in, rst_in          clock, synchronous active-high reset
//   start_in                pulse: begin a frame (honoured only when idle)
//   background_color_in[4]  palette index for the clear sweep
//   req_start_out[N]        one-cycle start pulse to all engines
//   req_valid_in[N]         engine write pending
//   req_addr_in[N*AW]       engine i address in [i*AW +: AW]
//   req_color_in[N*4]       engine i colour in [i*4 +: 4]
//   req_ready_out[N]        one-hot grant, transfer = valid & ready
//   req_done_in[N]          engine finished (latched)
//   write_addr_out[AW]      port-B address
//   write_data_out[4]       port-B data
//   write_valid_out         port-B write enable
//   busy_out                not idle
//   frame_done_out          one-cycle end-of-frame pulse
//   overflow_out            sticky: out-of-range address dropped this frame

module framebuffer_write_scheduler
   import render_pkg::*;
#(
   parameter int PIXEL_WIDTH  = 1280,
   parameter int PIXEL_HEIGHT = 720,
   parameter int NUM_REQ      = 4,
   parameter int CLEAR_EN     = 1,
   parameter int PIXEL_TOTAL  = PIXEL_WIDTH * PIXEL_HEIGHT,
   parameter int AW           = addr_width(PIXEL_WIDTH, PIXEL_HEIGHT)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [3:0]            background_color_in,
   output logic [NUM_REQ-1:0]    req_start_out,
   input  logic [NUM_REQ-1:0]    req_valid_in,
   input  logic [NUM_REQ*AW-1:0] req_addr_in,
   input  logic [NUM_REQ*4-1:0]  req_color_in,
   output logic [NUM_REQ-1:0]    req_ready_out,
   input  logic [NUM_REQ-1:0]    req_done_in,
   output logic [AW-1:0]         write_addr_out,
   output logic [3:0]            write_data_out,
   output logic                  write_valid_out,
   output logic                  busy_out,
   output logic                  frame_done_out,
   output logic                  overflow_out
);

   localparam int            PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [AW-1:0] TOTAL_A = AW'(PIXEL_TOTAL);
   localparam logic [AW-1:0] LAST_A  = AW'(PIXEL_TOTAL - 1);
   localparam logic [PW-1:0] LAST_P  = PW'(NUM_REQ - 1);

   sched_state_t         state;
   sched_state_t         state_next;
   logic [3:0]           bg_reg;
   logic [AW-1:0]        clear_cnt;
   logic [NUM_REQ-1:0]   done_mask;
   logic [PW-1:0]        ptr;

   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   gnt;
   logic                 xfer;
   logic                 all_done;
   logic [PW-1:0]        g_idx;
   logic [AW-1:0]        g_addr;
   logic [3:0]           g_color;
   logic                 g_in_range;

   assign all_done = &done_mask;

   // Engines that already reported done are never granted again this frame.
   assign eligible = (state == DRAW) ? (req_valid_in & ~done_mask) : '0;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_arb (
      .req (eligible),
      .ptr (ptr),
      .gnt (gnt)
   );

   assign req_ready_out = gnt;
   assign xfer          = |gnt;

   // Select the winning engine's address and colour.
   always_comb begin
      g_idx   = '0;
      g_addr  = '0;
      g_color = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            g_idx   = PW'(i);
            g_addr  = req_addr_in[i*AW +: AW];
            g_color = req_color_in[i*4 +: 4];
         end
      end
   end

   assign g_in_range = (g_addr < TOTAL_A);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_in) state_next = (CLEAR_EN != 0) ? CLEAR : DRAW;
         CLEAR:   if (clear_cnt == LAST_A) state_next = DRAW;
         DRAW:    if (all_done) state_next = FLUSH;
         FLUSH:   state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         bg_reg          <= '0;
         clear_cnt       <= '0;
         done_mask       <= '0;
         ptr             <= '0;
         req_start_out   <= '0;
         write_addr_out  <= '0;
         write_data_out  <= '0;
         write_valid_out <= 1'b0;
         overflow_out    <= 1'b0;
      end else begin
         state <= state_next;

         // Registered so the pulse lands in the first DRAW cycle, whichever
         // state DRAW was entered from.
         req_start_out <= (state_next == DRAW && state != DRAW) ? '1 : '0;

         write_valid_out <= 1'b0;

         case (state)
            IDLE: begin
               if (start_in) begin
                  bg_reg       <= background_color_in;
                  overflow_out <= 1'b0;
                  done_mask    <= '0;
                  clear_cnt    <= '0;
               end
            end
            CLEAR: begin
               write_valid_out <= 1'b1;
               write_addr_out  <= clear_cnt;
               write_data_out  <= bg_reg;
               clear_cnt       <= (clear_cnt == LAST_A) ? '0 : clear_cnt + 1'b1;
            end
            DRAW: begin
               done_mask <= done_mask | req_done_in;
               if (xfer) begin
                  ptr <= (g_idx == LAST_P) ? '0 : g_idx + 1'b1;
                  // Out-of-range writes are acknowledged but never reach the buffer.
                  if (g_in_range) begin
                     write_valid_out <= 1'b1;
                     write_addr_out  <= g_addr;
                     write_data_out  <= g_color;
                  end else begin
                     overflow_out <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_out       = (state != IDLE);
   assign frame_done_out = (state == FINISH);

endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// tb/tb_framebuffer_write_scheduler.sv - randomized and directed bench with behavioural frame model
module tb_framebuffer_write_scheduler;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int N     = 3;
   localparam int TOTAL = W * H;
   localparam int AW    = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, start, rst_b, start_b;
   logic [3:0]      bg;
   logic [N-1:0]    rvalid, rdone;
   logic [N*AW-1:0] raddr;
   logic [N*4-1:0]  rcolor;

   logic [N-1:0]    rstart, rready, rstart_b, rready_b;
   logic [AW-1:0]   waddr, waddr_b;
   logic [3:0]      wdata, wdata_b;
   logic            wvalid, busy, fdone, ovf;
   logic            wvalid_b, busy_b, fdone_b, ovf_b;

   framebuffer_write_scheduler #(
      .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .NUM_REQ(N), .CLEAR_EN(1)
   ) dut (
      .clk_in(clk), .rst_in(rst), .start_in(start), .background_color_in(bg),
      .req_start_out(rstart), .req_valid_in(rvalid), .req_addr_in(raddr),
      .req_color_in(rcolor), .req_ready_out(rready), .req_done_in(rdone),
      .write_addr_out(waddr), .write_data_out(wdata), .write_valid_out(wvalid),
      .busy_out(busy), .frame_done_out(fdone), .overflow_out(ovf)
   );

   framebuffer_write_scheduler #(
      .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .NUM_REQ(N), .CLEAR_EN(0)
   ) dut_b (
      .clk_in(clk), .rst_in(rst_b), .start_in(start_b), .background_color_in(bg),
      .req_start_out(rstart_b), .req_valid_in(rvalid), .req_addr_in(raddr),
      .req_color_in(rcolor), .req_ready_out(rready_b), .req_done_in(rdone),
      .write_addr_out(waddr_b), .write_data_out(wdata_b), .write_valid_out(wvalid_b),
      .busy_out(busy_b), .frame_done_out(fdone_b), .overflow_out(ovf_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model of dut (phase: 0 idle, 1 clear, 2 draw, 3 flush, 4 finish)
   int           m_phase = 0;
   int           m_clear = 0;
   int           m_ptr   = 0;
   logic [3:0]   m_bg    = '0;
   logic [N-1:0] m_done  = '0;
   logic         m_ovf   = 1'b0;
   logic         m_start = 1'b0;
   logic         m_wv    = 1'b0;
   int           m_wa    = 0;
   int           m_wd    = 0;

   // Observation logs used by the literal checks
   int           wlog_a[$];
   int           wlog_d[$];
   logic [N-1:0] gq[$];
   int           rs_count = 0, rs_addr = 0, rs_wv = 0;
   int           fd_count = 0, g0_count = 0, g1_count = 0;

   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int g;
      exp_rdy = '0;
      g = -1;
      if (m_phase == 2) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && rvalid[i] && !m_done[i]) g = i;
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
      end

      chk("ready", 32'(rready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("frame_done", 32'(fdone), 32'(m_phase == 4));
      chk("req_start", 32'(rstart), m_start ? ((1 << N) - 1) : 0);
      chk("write_valid", 32'(wvalid), 32'(m_wv));
      if (m_wv) begin
         chk("write_addr", 32'(waddr), m_wa);
         chk("write_data", 32'(wdata), m_wd);
      end
      chk("overflow", 32'(ovf), 32'(m_ovf));

      if (wvalid) begin
         wlog_a.push_back(int'(waddr));
         wlog_d.push_back(int'(wdata));
      end
      if (rready != '0) gq.push_back(rready);
      if (rstart != '0) begin
         rs_count++;
         rs_addr = int'(waddr);
         rs_wv   = int'(wvalid);
      end
      if (fdone) fd_count++;
      if (rready[0]) g0_count++;
      if (rready[1]) g1_count++;

      if (rst) begin
         m_phase = 0; m_clear = 0; m_ptr = 0; m_bg = '0; m_done = '0;
         m_ovf = 1'b0; m_start = 1'b0; m_wv = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               m_start = 1'b0; m_wv = 1'b0;
               if (start) begin
                  m_bg = bg; m_ovf = 1'b0; m_done = '0; m_clear = 0; m_phase = 1;
               end
            end
            1: begin
               m_wv = 1'b1; m_wa = m_clear; m_wd = int'(m_bg); m_start = 1'b0;
               m_clear++;
               if (m_clear == TOTAL) begin
                  m_phase = 2; m_start = 1'b1;
               end
            end
            2: begin
               m_start = 1'b0; m_wv = 1'b0;
               if (&m_done) begin
                  m_phase = 3;
               end else begin
                  if (g >= 0) begin
                     if (int'(raddr[g*AW +: AW]) < TOTAL) begin
                        m_wv = 1'b1;
                        m_wa = int'(raddr[g*AW +: AW]);
                        m_wd = int'(rcolor[g*4 +: 4]);
                     end else begin
                        m_ovf = 1'b1;
                     end
                     m_ptr = (g + 1) % N;
                  end
                  m_done = m_done | rdone;
               end
            end
            3: begin m_start = 1'b0; m_wv = 1'b0; m_phase = 4; end
            default: begin m_start = 1'b0; m_wv = 1'b0; m_phase = 0; end
         endcase
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int e, input int a, input int c);
      raddr[e*AW +: AW] = AW'(a);
      rcolor[e*4 +: 4]  = 4'(c);
   endtask

   logic [N-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   initial begin
      int snap, bad, fb;
      rst = 1'b1; rst_b = 1'b1; start = 1'b0; start_b = 1'b0; bg = '0;
      rvalid = '0; rdone = '0; raddr = '0; rcolor = '0;
      repeat (3) cyc();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wvalid", 32'(wvalid), 0);
      chk("rst_req_start", 32'(rstart), 0);
      chk("rst_overflow", 32'(ovf), 0);
      rst = 1'b0;
      cyc();

      // Frame 1: clear sweep with background E, engines already requesting
      bg = 4'hE;
      set_req(0, 10, 1); set_req(1, 11, 2); set_req(2, 12, 3);
      rvalid = '1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (32) cyc();
      repeat (6) cyc();
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_grant%0d", i), (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF, 32'(rr_exp[i]));
      bad = 0;
      for (int i = 0; i < 32; i++)
         if (i >= wlog_a.size() || wlog_a[i] != i || wlog_d[i] != 14) bad++;
      chk("clear_sweep_bad", bad, 0);
      chk("draw_write0", (wlog_a.size() > 32) ? wlog_a[32] : -1, 10);
      chk("draw_write2", (wlog_a.size() > 34) ? wlog_a[34] : -1, 12);
      chk("req_start_count", rs_count, 1);
      chk("req_start_with_last_clear", rs_addr, 31);
      chk("req_start_wvalid", rs_wv, 1);

      // Engine 1 done while engine 0 keeps requesting
      rvalid = 3'b011; rdone = 3'b010;
      cyc();
      rdone = '0;
      snap = g1_count;
      repeat (4) cyc();
      chk("eng1_excluded", g1_count, snap);

      // Out-of-range address from engine 2
      rvalid = 3'b100; set_req(2, 40, 9);
      #1;
      chk("oor_ready", 32'(rready), 32'(3'b100));
      cyc();
      rvalid = '0;
      chk("oor_no_write", 32'(wvalid), 0);
      chk("oor_overflow", 32'(ovf), 1);

      // Random traffic, stray start pulses must be ignored
      for (int c = 0; c < 150; c++) begin
         rvalid = 3'($urandom);
         for (int e = 0; e < N; e++) set_req(e, $urandom_range(0, 47), $urandom_range(0, 15));
         start = ($urandom_range(0, 19) == 0);
         cyc();
      end
      start = 1'b0;

      // Valid, ready and done together on engine 0
      rvalid = 3'b001; set_req(0, 5, 7); rdone = 3'b001;
      #1;
      chk("vd_ready", 32'(rready), 32'(3'b001));
      cyc();
      rdone = '0;
      chk("vd_write_valid", 32'(wvalid), 1);
      chk("vd_write_addr", 32'(waddr), 5);
      chk("vd_write_data", 32'(wdata), 7);
      snap = g0_count;
      for (int c = 0; c < 10; c++) begin
         rvalid = 3'($urandom);
         for (int e = 0; e < N; e++) set_req(e, $urandom_range(0, 31), $urandom_range(0, 15));
         cyc();
      end
      chk("eng0_excluded", g0_count, snap);

      // Last engine done: flush, finish, back to idle
      rvalid = '0; rdone = 3'b100;
      cyc();
      rdone = '0;
      snap = fd_count;
      repeat (6) cyc();
      chk("frame_done_pulses", fd_count - snap, 1);
      chk("busy_after_frame", 32'(busy), 0);
      chk("overflow_sticky", 32'(ovf), 1);

      // Frame 2: overflow cleared by start, random draw, reset mid-frame
      bg = 4'h3; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("overflow_cleared", 32'(ovf), 0);
      for (int c = 0; c < 80; c++) begin
         rvalid = 3'($urandom);
         for (int e = 0; e < N; e++) begin
            set_req(e, $urandom_range(0, 40), $urandom_range(0, 15));
            rdone[e] = ($urandom_range(0, 39) == 0);
         end
         start = ($urandom_range(0, 29) == 0);
         cyc();
      end
      start = 1'b0; rdone = '0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_wvalid", 32'(wvalid), 0);
      chk("midrst_ready", 32'(rready), 0);
      chk("midrst_overflow", 32'(ovf), 0);
      rvalid = '0;
      cyc();

      // Instance without clear sweep
      chk("b_rst_busy", 32'(busy_b), 0);
      rst_b = 1'b0;
      cyc();
      rvalid = 3'b010; set_req(1, 9, 4); start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      chk("b_req_start", 32'(rstart_b), 32'(3'b111));
      chk("b_busy", 32'(busy_b), 1);
      chk("b_ready", 32'(rready_b), 32'(3'b010));
      cyc();
      rvalid = '0;
      chk("b_write_valid", 32'(wvalid_b), 1);
      chk("b_write_addr", 32'(waddr_b), 9);
      chk("b_write_data", 32'(wdata_b), 4);
      chk("b_overflow", 32'(ovf_b), 0);
      rst_b = 1'b1;
      cyc();
      rst_b = 1'b0;
      chk("b_midrst_busy", 32'(busy_b), 0);
      chk("b_midrst_req_start", 32'(rstart_b), 0);
      chk("b_midrst_wvalid", 32'(wvalid_b), 0);
      start_b = 1'b1;
      cyc();
      start_b = 1'b0;
      chk("b_restart_req_start", 32'(rstart_b), 32'(3'b111));
      rdone = '1;
      cyc();
      rdone = '0;
      chk("b_req_start_one_cycle", 32'(rstart_b), 0);
      fb = 0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         if (fdone_b) fb++;
      end
      chk("b_frame_done", fb, 1);
      chk("b_busy_end", 32'(busy_b), 0);
      chk("b_frame_done_idle", 32'(fdone_b), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/framebuffer_write_scheduler.md
Name: framebuffer_write_scheduler

Overview:
- Sequences one frame of drawing into the pixel framebuffer's write port (port B).
- First it sweeps the whole buffer with the background colour. Then it releases up to NUM_REQ drawing engines (polygon drawers and similar) and round-robin arbitrates their pixel writes onto the single write port.
- It signals frame completion once every engine has reported done.
- Sits between the render top-level state machine and the drawing engines.

Parameters:
- PIXEL_WIDTH, 1280, image width in pixels
- PIXEL_HEIGHT, 720, image height in pixels
- NUM_REQ, 4, number of drawing engines sharing the write port (2..8)
- CLEAR_EN, 1, 1 = run the CLEAR sweep before DRAW; 0 = go straight to DRAW
- Derived: PIXEL_TOTAL = PIXEL_WIDTH*PIXEL_HEIGHT; AW = $clog2(PIXEL_TOTAL)+1

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse: begin a frame
- background_color_in  input  4  palette index used for CLEAR
- req_start_out  output  NUM_REQ  one-cycle start pulse to every engine
- req_valid_in  input  NUM_REQ  engine i has a pixel write pending
- req_addr_in  input  NUM_REQ*AW  packed addresses; engine i in bits [i*AW +: AW]
- req_color_in  input  NUM_REQ*4  packed palette indices; engine i in bits [i*4 +: 4]
- req_ready_out  output  NUM_REQ  one-hot grant; a transfer occurs when valid & ready
- req_done_in  input  NUM_REQ  engine i done (one-cycle pulse or level; latched internally)
- write_addr_out  output  AW  framebuffer port-B address
- write_data_out  output  4  framebuffer port-B data
- write_valid_out  output  1  framebuffer port-B write enable
- busy_out  output  1  high in any state other than IDLE
- frame_done_out  output  1  one-cycle pulse at end of frame
- overflow_out  output  1  sticky flag: an out-of-range address was dropped this frame

Behaviour:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high on rst_in. Reset may arrive in any state.
- Reset values: state=IDLE; every output 0; done mask, round-robin pointer and clear counter all 0.
- States: IDLE, CLEAR, DRAW, FLUSH, FINISH.
- IDLE:
  - On start_in: capture background_color_in into bg_reg, clear overflow_out and the done mask.
  - Go to CLEAR if CLEAR_EN=1, else DRAW.
  - start_in in any other state is ignored.
- CLEAR:
  - One write per cycle: addr = clear_cnt, data = bg_reg, clear_cnt counts 0..PIXEL_TOTAL-1.
  - After the write to PIXEL_TOTAL-1 is issued, next state is DRAW.
  - CLEAR lasts exactly PIXEL_TOTAL cycles.
  - req_ready_out = 0 throughout.
- DRAW entry:
  - req_start_out = all ones for exactly one cycle, asserted (registered) in the first DRAW cycle.
  - Arbitration is live in that same cycle.
- DRAW arbitration:
  - Eligible requesters are req_valid_in & ~done_mask.
  - Grant the first eligible index at or after ptr, wrapping modulo NUM_REQ.
  - req_ready_out is combinational from the eligible set and ptr, at most one bit set.
  - On a transfer by index g, ptr <= (g+1) mod NUM_REQ. With no transfer, ptr holds.
- Write pipeline: one register stage. A transfer in cycle t drives write_addr/data_out with write_valid_out=1 in cycle t+1.
- Address range: if the granted address is >= PIXEL_TOTAL, the transfer is still acknowledged, write_valid_out stays 0, and overflow_out is set to 1.
- Done latching:
  - done_mask[i] is set on req_done_in[i] in DRAW.
  - If valid, ready and done coincide for engine i, the write is accepted and done is latched.
  - Once done_mask[i] is set, req_ready_out[i] = 0 for the rest of the frame.
  - req_done_in outside DRAW is ignored.
- DRAW exit: when done_mask is all ones, go to FLUSH; the final registered write drains there.
- FLUSH → FINISH after 1 cycle.
- FINISH: frame_done_out = 1 for one cycle, busy_out drops, next state IDLE.
- Widths: clear_cnt is AW bits; comparisons against PIXEL_TOTAL are unsigned.
- Reset mid-CLEAR or mid-DRAW abandons the frame. No frame_done_out is issued.

Decomposition:
- Package render_pkg:
  - 16 palette index constants (BLACK..LBLUE, 4-bit).
  - Scheduler state enum (IDLE, CLEAR, DRAW, FLUSH, FINISH).
  - Function addr_width(w,h) returning $clog2(w*h)+1.
- Sub-module rr_arbiter: combinational, parameter N. Inputs req[N] and ptr; output one-hot gnt[N]. Instantiated once.

Test Plan (PIXEL_WIDTH=8, PIXEL_HEIGHT=4, NUM_REQ=3):
- Clear sweep: start_in, background_color_in=4'hE, CLEAR_EN=1 -> 32 consecutive writes, addr 0..31, data E; req_start_out=3'b111 in the next cycle; ready all 0 during CLEAR.
- Round-robin fairness: all three engines hold valid with distinct addresses -> grants 0,1,2,0,1,2 on consecutive cycles; each write appears on write_*_out exactly 1 cycle after its grant.
- Skip and done: engine 1 asserts done while engine 0 keeps valid -> engine 1 never granted again; after done from 0 and 2 -> FLUSH, then frame_done_out pulses once, busy_out falls.
- Out-of-range address: engine 2 sends addr 40 -> ready asserted, no write_valid_out, overflow_out=1 until the next start_in.
- Simultaneous valid and done: engine 0 asserts valid, ready and done in the same cycle with addr 5 -> write to 5 occurs; engine 0 is excluded afterwards.
- Reset mid-DRAW, then start_in with CLEAR_EN=0 -> outputs 0 after reset; the new frame enters DRAW directly and req_start_out pulses in the cycle after start_in.
